mips_cpu_muldiv: RTL
====================

Name: mips_cpu_muldiv

Overview:
Parametrised iterative multiply/divide unit that owns the HI/LO architectural registers for the MIPS CPU core. It replaces single-cycle combinational MULT/MULTU/DIV/DIVU logic with a synthesisable one-bit-per-cycle shift/add (multiply) and restoring-division datapath. The core issues an operation and stalls on busy. MFHI/MFLO read hi/lo directly.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits.
CNT_W, $clog2(WIDTH), localparam; iteration counter width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
clk_enable  input  1  global advance enable; when low all state holds
start  input  1  issue request, sampled on a rising edge with clk_enable=1
op  input  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
operand_a  input  WIDTH  Rs value (dividend / multiplicand / MTHI-MTLO source)
operand_b  input  WIDTH  Rt value (divisor / multiplier)
busy  output  1  high while an operation is in flight; core must stall MF*/MULT*/DIV*/MT*
done  output  1  one-cycle pulse when hi/lo carry a new MULT/DIV result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, wins over clk_enable): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators cleared. Reset mid-operation abandons the operation with no hi/lo update.
- clk_enable=0: every register holds, including state, counter and done. Latency extends by the number of disabled cycles.
- States: IDLE, CALC, FIXUP. busy = (state != IDLE). done is registered.
- IDLE, start=1, op in MULT/MULTU/DIV/DIVU:
  - Latch |operand_a| and |operand_b| for signed ops, or raw values for unsigned ops.
  - Latch sign_a, sign_b and the op.
  - counter=WIDTH-1; go to CALC.
- IDLE, start=1, op=MTHI/MTLO: hi (or lo) <= operand_a on that edge. busy stays 0 and done stays 0.
- start while busy=1: ignored, with no effect on the operation in flight.
- Invalid op code: ignored.
- CALC: one iteration per enabled edge, exactly WIDTH iterations.
  - Multiply: conditional add of the multiplicand into the upper half of a 2*WIDTH accumulator, then shift right.
  - Divide: restoring step. Shift the remainder left with the next dividend bit, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - When counter==0 the last iteration completes and the state goes to FIXUP. Otherwise decrement counter.
- FIXUP (1 cycle). On exit: write hi/lo, done<=1, state<=IDLE.
  - MULT: negate the 2*WIDTH product if sign_a^sign_b. hi=upper half, lo=lower half.
  - MULTU: no fixup.
  - DIV: negate the quotient if sign_a^sign_b; the remainder takes the sign of the dividend. lo=quotient, hi=remainder.
  - Divide by zero (any divide): lo={WIDTH{1}}, hi=operand_a as originally issued (raw, not magnitude). No sign fixup.
  - DIV of most-negative by -1: lo=most-negative, hi=0 (natural wrap, no trap).
- Timing: start accepted at edge E0. busy is high from after E0 to after E_{WIDTH+1} (WIDTH+1 cycles). hi/lo update and done=1 follow E_{WIDTH+1}, and done clears on the next enabled edge.
- start may be asserted in the same cycle done=1 (state is IDLE). A new operation is accepted back-to-back.
- hi/lo keep their old values throughout CALC/FIXUP.

Decomposition:
- Package mips_cpu_muldiv_pkg contains muldiv_op_t (3-bit enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5) and muldiv_state_t (IDLE, CALC, FIXUP). The CPU decode imports the package to map funct codes to op.
- One sub-module, mips_cpu_muldiv_step: combinational single-iteration step.
  - Inputs: mode, accumulator/remainder, operand.
  - Outputs: next accumulator, next quotient bit.
  - Parametrised by WIDTH, so a future two-bits-per-cycle variant instantiates it twice.

Test Plan:
- MULT, a=FFFFFFFD (-3), b=00000005 -> busy high 33 cycles, then done pulse, hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU, a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Second start in the done cycle (MULTU 2*3) -> lo=00000006, hi=0, 33 cycles later.
- DIV, a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000/FFFFFFFF -> lo=80000000, hi=00000000.
- DIVU, a=00001234, b=0 -> lo=FFFFFFFF, hi=00001234. DIV a=FFFFFFF0, b=0 -> lo=FFFFFFFF, hi=FFFFFFF0.
- MTHI a=CAFEF00D while idle -> hi=CAFEF00D next cycle, busy never rises. MTLO issued while busy -> lo unchanged. start during CALC -> ignored, result unaffected.
- clk_enable low for 5 cycles mid-CALC -> done arrives 38 cycles after start. Reset asserted at iteration 10 -> hi=lo=0, busy=0, no done pulse.

Source files
------------

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the iterative HI/LO multiply/divide unit.
// The CPU decode imports this to map funct codes onto muldiv_op_t.
package mips_cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;

  function automatic logic is_muldiv_op(input muldiv_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_mul_op(input muldiv_op_t op);
    return (op == MULT) || (op == MULTU);
  endfunction

  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Issue/result bundle between the CPU core (master) and the muldiv unit (slave).
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
) ();
  import mips_cpu_muldiv_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv_step.sv
// One iteration of shift/add multiply or restoring divide on a 2*WIDTH accumulator.
// For divide, acc_out[0] is left clear and the quotient bit comes out on q_bit.
module mips_cpu_muldiv_step
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               mode_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out,
  output logic               q_bit
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] trial_s;

  // Single-iteration arithmetic for both modes
  always_comb begin
    sum_s    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} +
               (acc_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Remainder shifted left, pulling in the next dividend bit
    rem_sh_s = acc_in[2*WIDTH-1:WIDTH-1];
    trial_s  = rem_sh_s - {1'b0, operand};
    if (mode_div) begin
      if (!trial_s[WIDTH]) begin
        acc_out = {trial_s[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
        q_bit   = 1'b1;
      end else begin
        acc_out = {rem_sh_s[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
        q_bit   = 1'b0;
      end
    end else begin
      acc_out = {sum_s, acc_in[WIDTH-1:1]};
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative one-bit-per-cycle multiply/divide unit owning the MIPS HI/LO registers.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  input logic              clk_enable,
  mips_cpu_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               accept_s;
  logic               issue_signed_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [2*WIDTH-1:0] step_acc_s;
  logic               step_qbit_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s;

  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (!is_mul_op(op_q)),
    .acc_in   (acc_q),
    .operand  (opnd_q),
    .acc_out  (step_acc_s),
    .q_bit    (step_qbit_s)
  );

  // State and datapath registers; reset wins over clk_enable
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= MULT;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      raw_a_q  <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (clk_enable) begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      raw_a_q  <= raw_a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = CALC;
        else          state_d = IDLE;
      end
      CALC: begin
        if (cnt_q == {CNT_W{1'b0}}) state_d = FIXUP;
        else                        state_d = CALC;
      end
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand conditioning and sign/remainder fixups
  always_comb begin
    accept_s       = (state_q == IDLE) && bus.start && is_muldiv_op(bus.op);
    issue_signed_s = is_signed_op(bus.op);
    mag_a_s = (issue_signed_s && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
    mag_b_s = (issue_signed_s && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
    prod_s  = ((op_q == MULT) && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
    quot_s  = ((op_q == DIV) && (sign_a_q ^ sign_b_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s   = ((op_q == DIV) && sign_a_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Datapath and output next values
  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    raw_a_d  = raw_a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    done_d   = 1'b0;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d     = bus.op;
          sign_a_d = issue_signed_s & bus.operand_a[WIDTH-1];
          sign_b_d = issue_signed_s & bus.operand_b[WIDTH-1];
          raw_a_d  = bus.operand_a;
          cnt_d    = CNT_W'(WIDTH - 1);
          // Multiplier/dividend rides in the low half; the other operand is added/subtracted
          if (is_mul_op(bus.op)) begin
            opnd_d = mag_a_s;
            acc_d  = {{WIDTH{1'b0}}, mag_b_s};
          end else begin
            opnd_d = mag_b_s;
            acc_d  = {{WIDTH{1'b0}}, mag_a_s};
          end
        end else if (bus.start && (bus.op == MTHI)) begin
          hi_d = bus.operand_a;
        end else if (bus.start && (bus.op == MTLO)) begin
          lo_d = bus.operand_a;
        end else begin
          acc_d = acc_q;
        end
      end
      CALC: begin
        if (is_mul_op(op_q)) acc_d = step_acc_s;
        else                 acc_d = {step_acc_s[2*WIDTH-1:1], step_qbit_s};
        if (cnt_q == {CNT_W{1'b0}}) cnt_d = cnt_q;
        else                        cnt_d = cnt_q - CNT_W'(1);
      end
      FIXUP: begin
        done_d = 1'b1;
        if (is_mul_op(op_q)) begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end else if (opnd_q == {WIDTH{1'b0}}) begin
          hi_d = raw_a_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem_s;
          lo_d = quot_s;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
